// File: rtl/mem_write_arbiter_if.sv
// Bus bundle between the write arbiter and its three writers plus the memory port.
// master = requesters/observer side, slave = arbiter side.
interface mem_write_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              prog;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              manual_key;
  logic [ADDR_W-1:0] manual_addr;
  logic [DATA_W-1:0] manual_data;
  logic              serial_req;
  logic [ADDR_W-1:0] serial_addr;
  logic [DATA_W-1:0] serial_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              manual_ack;
  logic              serial_ack;
  logic              serial_ovf;
  logic              busy;
  logic [CNT_W-1:0]  wr_count;

  // Handshakes: cpu_req is a level held until the cpu_gnt pulse; serial_req is a
  // 1-cycle pulse; manual_key requests on its rising edge. Every ack/gnt is a
  // 1-cycle pulse coincident with the mem_we of that writer's write.
  modport master (
    output prog, cpu_req, cpu_addr, cpu_data,
    output manual_key, manual_addr, manual_data,
    output serial_req, serial_addr, serial_data,
    input  mem_we, mem_addr, mem_wdata, cpu_gnt, cpu_stall,
    input  manual_ack, serial_ack, serial_ovf, busy, wr_count
  );

  modport slave (
    input  prog, cpu_req, cpu_addr, cpu_data,
    input  manual_key, manual_addr, manual_data,
    input  serial_req, serial_addr, serial_data,
    output mem_we, mem_addr, mem_wdata, cpu_gnt, cpu_stall,
    output manual_ack, serial_ack, serial_ovf, busy, wr_count
  );
endinterface

// File: rtl/mem_write_arbiter.sv
// Single write-port arbiter for the 16x8 memory: CPU in run mode, serial/manual
// loaders (one buffered request each, serial first) in program mode.
module mem_write_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  mem_write_arbiter_if.slave bus,
  output logic               fsm_state
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_MAN  = 2'd2,
    SRC_SER  = 2'd3
  } src_t;

  state_t            state, next_state;
  src_t              src, grant;
  logic              key_q;
  logic              m_pend, s_pend;
  logic [ADDR_W-1:0] m_addr_q, s_addr_q, sel_addr, mem_addr_q;
  logic [DATA_W-1:0] m_data_q, s_data_q, sel_data, mem_wdata_q;
  logic [CNT_W-1:0]  count_q;
  logic              serial_ovf_q;
  logic              m_edge, s_take, m_take;

  // Loaders are arbitrated from their buffers only; the CPU holds its own
  // address/data stable, so it is granted straight from the request level.
  always_comb begin
    next_state = state;
    grant      = SRC_NONE;
    case (state)
      IDLE: begin
        if (bus.prog) begin
          if (s_pend)      grant = SRC_SER;
          else if (m_pend) grant = SRC_MAN;
        end else if (bus.cpu_req) begin
          grant = SRC_CPU;
        end
        if (grant != SRC_NONE) next_state = WRITE;
      end
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sel_addr = s_addr_q;
    sel_data = s_data_q;
    case (grant)
      SRC_CPU: begin
        sel_addr = bus.cpu_addr;
        sel_data = bus.cpu_data;
      end
      SRC_MAN: begin
        sel_addr = m_addr_q;
        sel_data = m_data_q;
      end
      default: begin
        sel_addr = s_addr_q;
        sel_data = s_data_q;
      end
    endcase
  end

  // A new request is accepted when the buffer is free or is being drained
  // this very cycle; otherwise it is dropped and the old contents are kept.
  assign m_edge = bus.manual_key & ~key_q;
  assign s_take = bus.serial_req & (~s_pend | (grant == SRC_SER));
  assign m_take = m_edge & (~m_pend | (grant == SRC_MAN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      src          <= SRC_NONE;
      key_q        <= 1'b0;
      m_pend       <= 1'b0;
      s_pend       <= 1'b0;
      m_addr_q     <= '0;
      m_data_q     <= '0;
      s_addr_q     <= '0;
      s_data_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      count_q      <= '0;
      serial_ovf_q <= 1'b0;
    end else begin
      state <= next_state;
      src   <= grant;
      key_q <= bus.manual_key;

      if (s_take) begin
        s_addr_q <= bus.serial_addr;
        s_data_q <= bus.serial_data;
        s_pend   <= 1'b1;
      end else if (grant == SRC_SER) begin
        s_pend <= 1'b0;
      end
      if (bus.serial_req && !s_take) serial_ovf_q <= 1'b1;

      if (m_take) begin
        m_addr_q <= bus.manual_addr;
        m_data_q <= bus.manual_data;
        m_pend   <= 1'b1;
      end else if (grant == SRC_MAN) begin
        m_pend <= 1'b0;
      end

      // The count advances with the grant so it already reflects the write
      // during the mem_we cycle.
      if (grant != SRC_NONE) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_data;
        count_q     <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.mem_we     = (state == WRITE);
  assign bus.cpu_gnt    = (state == WRITE) && (src == SRC_CPU);
  assign bus.manual_ack = (state == WRITE) && (src == SRC_MAN);
  assign bus.serial_ack = (state == WRITE) && (src == SRC_SER);
  assign bus.cpu_stall  = bus.cpu_req & ~bus.cpu_gnt;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.wr_count   = count_q;
  assign bus.serial_ovf = serial_ovf_q;
  assign bus.busy       = (state != IDLE) | s_pend | m_pend;
  assign fsm_state      = state;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: scoreboard of expected writes (writer, addr, data)
// popped on every mem_we, plus directed timing checks around each scenario.
module tb_mem_write_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int W      = 2 + ADDR_W + DATA_W;

  localparam logic [1:0] S_CPU = 2'd1;
  localparam logic [1:0] S_MAN = 2'd2;
  localparam logic [1:0] S_SER = 2'd3;

  logic clk;
  logic rst;
  logic fsm_state;

  mem_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  mem_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] exp_count;
  int               n_cmp;
  int               n_err;
  int               n_writes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input logic [1:0] s, input logic [ADDR_W-1:0] a,
                                   input logic [DATA_W-1:0] d);
    exp_q.push_back({s, a, d});
  endfunction

  // Every memory write is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      logic [1:0]   obs_src;
      logic [W-1:0] exp_w;
      n_writes++;
      obs_src = bus.cpu_gnt ? S_CPU : bus.manual_ack ? S_MAN : bus.serial_ack ? S_SER : 2'd0;
      check("sb_one_ack", 32'($countones({bus.cpu_gnt, bus.manual_ack, bus.serial_ack})), 32'd1);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", {obs_src, bus.mem_addr, bus.mem_wdata}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check("sb_write", {obs_src, bus.mem_addr, bus.mem_wdata}, exp_w);
        exp_count = exp_count + 1'b1;
        check("sb_wr_count", bus.wr_count, exp_count);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    exp_count = '0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic seen;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_data = d;
    push_exp(S_CPU, a, d);
    seen = 1'b0;
    for (int t = 0; t < 4 && !seen; t++) begin
      tick();
      seen = bus.cpu_gnt;
    end
    check("cpu_gnt_seen", 32'(seen), 32'd1);
    bus.cpu_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int ser_cyc;
    int man_cyc;
    int n_acks;
    int lat;

    n_cmp = 0; n_err = 0; n_writes = 0; exp_count = '0;
    rst = 1'b0;
    bus.prog = 1'b0; bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.manual_key = 1'b0; bus.manual_addr = '0; bus.manual_data = '0;
    bus.serial_req = 1'b0; bus.serial_addr = '0; bus.serial_data = '0;

    // Reset state
    do_reset();
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    check("rst_wr_count",   32'(bus.wr_count),   32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_serial_ovf", 32'(bus.serial_ovf), 32'd0);
    check("rst_acks", 32'({bus.cpu_gnt, bus.manual_ack, bus.serial_ack, bus.cpu_stall}), 32'd0);
    check("rst_state",      32'(fsm_state),      32'd0);

    // T1: single serial write, buffered then written
    bus.prog = 1'b1;
    bus.serial_req = 1'b1; bus.serial_addr = 4'd3; bus.serial_data = 8'hA5;
    push_exp(S_SER, 4'd3, 8'hA5);
    tick();
    bus.serial_req = 1'b0;
    check("t1_pending_busy", 32'(bus.busy),   32'd1);
    check("t1_no_we_yet",    32'(bus.mem_we), 32'd0);
    tick();
    check("t1_mem_we",     32'(bus.mem_we),     32'd1);
    check("t1_mem_addr",   32'(bus.mem_addr),   32'd3);
    check("t1_mem_wdata",  32'(bus.mem_wdata),  32'hA5);
    check("t1_serial_ack", 32'(bus.serial_ack), 32'd1);
    check("t1_wr_count",   32'(bus.wr_count),   32'd1);
    drain("t1_drain");

    // T2: simultaneous serial and manual request, serial wins
    bus.serial_req = 1'b1; bus.serial_addr = 4'd2; bus.serial_data = 8'h11;
    bus.manual_key = 1'b1; bus.manual_addr = 4'd5; bus.manual_data = 8'h22;
    push_exp(S_SER, 4'd2, 8'h11);
    push_exp(S_MAN, 4'd5, 8'h22);
    ser_cyc = -1; man_cyc = -1; n_acks = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      bus.serial_req = 1'b0;
      bus.manual_key = 1'b0;
      if (bus.serial_ack) begin ser_cyc = i; n_acks++; end
      if (bus.manual_ack) begin man_cyc = i; n_acks++; end
    end
    check("t2_serial_latency", 32'(ser_cyc), 32'd2);
    check("t2_manual_gap",     32'(man_cyc - ser_cyc), 32'd2);
    check("t2_ack_total",      32'(n_acks), 32'd2);

    // T3: second serial pulse lands while the buffer is full -> dropped;
    // a third pulse arriving as the buffer drains is captured
    bus.manual_key = 1'b1; bus.manual_addr = 4'd6; bus.manual_data = 8'h66;
    push_exp(S_MAN, 4'd6, 8'h66);
    tick();
    bus.serial_req = 1'b1; bus.serial_addr = 4'd8; bus.serial_data = 8'h44;
    push_exp(S_SER, 4'd8, 8'h44);
    tick();
    check("t3_manual_in_write", 32'(bus.manual_ack), 32'd1);
    check("t3_ovf_before",      32'(bus.serial_ovf), 32'd0);
    bus.serial_addr = 4'd9; bus.serial_data = 8'h55;
    tick();
    check("t3_ovf_set", 32'(bus.serial_ovf), 32'd1);
    bus.serial_addr = 4'hA; bus.serial_data = 8'h77;
    push_exp(S_SER, 4'hA, 8'h77);
    tick();
    bus.serial_req = 1'b0;
    bus.manual_key = 1'b0;
    drain("t3_drain");
    check("t3_ovf_sticky", 32'(bus.serial_ovf), 32'd1);

    // T4: CPU write in run mode, one stall cycle
    do_reset();
    bus.prog = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 4'hF; bus.cpu_data = 8'h3C;
    push_exp(S_CPU, 4'hF, 8'h3C);
    #1;
    check("t4_stall",       32'(bus.cpu_stall), 32'd1);
    check("t4_gnt_low",     32'(bus.cpu_gnt),   32'd0);
    tick();
    check("t4_gnt",         32'(bus.cpu_gnt),   32'd1);
    check("t4_mem_we",      32'(bus.mem_we),    32'd1);
    check("t4_stall_clear", 32'(bus.cpu_stall), 32'd0);
    bus.cpu_req = 1'b0;
    drain("t4_drain");

    // T4b: cpu_req is ignored in program mode and stays stalled
    bus.prog = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_addr = 4'd2; bus.cpu_data = 8'h05;
    base = n_writes;
    repeat (5) tick();
    check("t4b_stall_prog", 32'(bus.cpu_stall), 32'd1);
    check("t4b_no_write",   32'(n_writes - base), 32'd0);
    bus.cpu_req = 1'b0;
    tick();

    // T5: manual request held in run mode, written once prog=1
    bus.prog = 1'b0;
    bus.manual_key = 1'b1; bus.manual_addr = 4'd7; bus.manual_data = 8'h99;
    push_exp(S_MAN, 4'd7, 8'h99);
    base = n_writes;
    tick();
    bus.manual_key = 1'b0;
    repeat (10) tick();
    check("t5_held_no_write", 32'(n_writes - base), 32'd0);
    check("t5_held_busy",     32'(bus.busy), 32'd1);
    bus.prog = 1'b1;
    lat = 0;
    while (!bus.mem_we && lat < 3) begin
      tick();
      lat++;
    end
    check("t5_write_within_2", 32'(bus.mem_we && lat <= 2), 32'd1);
    check("t5_manual_ack",     32'(bus.manual_ack), 32'd1);
    drain("t5_drain");

    // T6: reset during WRITE discards the pending manual request
    bus.serial_req = 1'b1; bus.serial_addr = 4'd1; bus.serial_data = 8'h12;
    bus.manual_key = 1'b1; bus.manual_addr = 4'd2; bus.manual_data = 8'h34;
    push_exp(S_SER, 4'd1, 8'h12);
    tick();
    bus.serial_req = 1'b0;
    bus.manual_key = 1'b0;
    tick();
    check("t6_in_write", 32'(bus.serial_ack), 32'd1);
    rst = 1'b1;
    tick();
    check("t6_we_after_rst",  32'(bus.mem_we),   32'd0);
    check("t6_acks_after_rst", 32'({bus.cpu_gnt, bus.manual_ack, bus.serial_ack}), 32'd0);
    check("t6_busy_after_rst", 32'(bus.busy),     32'd0);
    check("t6_count_after_rst", 32'(bus.wr_count), 32'd0);
    check("t6_addr_after_rst", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    exp_count = '0;
    base = n_writes;
    repeat (5) tick();
    check("t6_discarded", 32'(n_writes - base), 32'd0);
    check("t6_idle_busy", 32'(bus.busy), 32'd0);

    // T6b: 256 CPU writes wrap wr_count back to 0
    bus.prog = 1'b0;
    for (int i = 0; i < 256; i++) begin
      cpu_write(ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom_range(0, 255)));
    end
    tick();
    check("t6_count_wrap", 32'(bus.wr_count), 32'd0);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
